// File: rtl/efuse_prog_seq_if.sv
// eFuse macro port bundle: the sequencer drives the master side, the fuse macro
// (or its model) sits on the slave side.
interface efuse_prog_seq_if #(
  parameter int NBITS = 256,
  parameter int DW    = 8
);
  logic                     efuse_pgmen;
  logic                     efuse_rden;
  logic                     efuse_aen;
  logic [$clog2(NBITS)-1:0] efuse_addr;
  logic [DW-1:0]            efuse_d;

  modport master (
    output efuse_pgmen, efuse_rden, efuse_aen, efuse_addr,
    input  efuse_d
  );

  modport slave (
    input  efuse_pgmen, efuse_rden, efuse_aen, efuse_addr,
    output efuse_d
  );
endinterface

// File: rtl/efuse_prog_seq.sv
// eFuse program/read sequencer: bit-serial programming of a write window and
// word-serial reads of a read window. Optional readback check: EFUSE_PROG_VERIFY_EN.
module efuse_prog_seq #(
  parameter int NBITS = 256,
  parameter int DW    = 8,
  parameter int NW    = 64,
  parameter int NR    = 64,
  parameter int TW    = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          read_start,
  input  logic                          write_start,
  input  logic                          abort,
  input  logic [$clog2(NBITS/NR)-1:0]   read_sel,
  input  logic [$clog2(NBITS/NW)-1:0]   write_sel,
  input  logic [TW-1:0]                 rg_trd,
  input  logic [TW-1:0]                 rg_tpgm,
  input  logic [3:0]                    rg_tlow_rd,
  input  logic [3:0]                    rg_tlow_pgm,
  input  logic [NW-1:0]                 write_data,
  output logic [NR-1:0]                 read_data,
  efuse_prog_seq_if.master              efuse,
  output logic                          busy,
  output logic                          read_done,
  output logic                          write_done,
  output logic                          aborted,
  output logic                          verify_err
);

  localparam int AW     = $clog2(NBITS);
  localparam int IW     = $clog2(NW + NR) + 1;
  localparam int RWORDS = NR / DW;
  localparam int VWORDS = NW / DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_RECOV,
    S_VERIFY
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic          op_wr;
  logic          vfy;
  logic [AW-1:0] addr;
  logic [IW-1:0] idx;
  logic [IW-1:0] last_idx;
  logic [TW-1:0] cnt;
  logic [TW-1:0] t_pulse;
  logic [TW-1:0] t_recov;
  logic [TW-1:0] trd_q;
  logic [TW-1:0] tpgm_q;
  logic [3:0]    tlow_rd_q;
  logic [3:0]    tlow_pgm_q;
  logic [NW-1:0] wsh;
  logic          wr_phase;
  logic          pulse_last;
  logic          recov_last;
  logic          item_last;
  logic          accept_rd;
  logic          accept_wr;
  logic          finish;
  logic          abort_hit;

`ifdef EFUSE_PROG_VERIFY_EN
  logic [NW-1:0]                 wdata;
  logic [$clog2(NBITS/NW)-1:0]   wsel_q;
  logic                          verr;

  // Readback word k lands k words below the top of read_data (first word in MSBs).
  function automatic logic readback_miss(input logic [NW-1:0] w, input logic [NR-1:0] r);
    logic miss;
    miss = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (w[i] && !r[(VWORDS - 1 - i / DW) * DW + i % DW]) miss = 1'b1;
    end
    return miss;
  endfunction
`endif

  // Programming phase vs. read/verify phase selects timing and item count.
  assign wr_phase   = op_wr & ~vfy;
  assign t_pulse    = wr_phase ? tpgm_q : trd_q;
  assign t_recov    = wr_phase ? (wsh[0] ? TW'(tlow_pgm_q) : '0) : TW'(tlow_rd_q);
  assign last_idx   = wr_phase ? IW'(NW - 1) : (vfy ? IW'(VWORDS - 1) : IW'(RWORDS - 1));
  assign pulse_last = (cnt == t_pulse);
  assign recov_last = (cnt == t_recov);
  assign item_last  = (idx == last_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    finish    = 1'b0;
    abort_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (write_start) begin
          accept_wr = 1'b1;
          state_nx  = S_SETUP;
        end else if (read_start) begin
          accept_rd = 1'b1;
          state_nx  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!op_wr)                 state_nx = S_PULSE;
        else if (write_data == '0) begin
          state_nx = S_IDLE;
          finish   = 1'b1;
        end else if (write_data[0]) state_nx = S_PULSE;
        else                        state_nx = S_RECOV;
      end
      S_PULSE: begin
        if (pulse_last) state_nx = S_RECOV;
      end
      S_RECOV: begin
        if (recov_last) begin
          if (item_last) begin
`ifdef EFUSE_PROG_VERIFY_EN
            if (wr_phase) begin
              state_nx = S_VERIFY;
            end else begin
              state_nx = S_IDLE;
              finish   = 1'b1;
            end
`else
            state_nx = S_IDLE;
            finish   = 1'b1;
`endif
          end else if (wr_phase && !wsh[1]) begin
            // Next bit is 0: skip the pulse, spend a single recovery cycle on it.
            state_nx = S_RECOV;
          end else begin
            state_nx = S_PULSE;
          end
        end
      end
      S_VERIFY: state_nx = S_PULSE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nx  = S_IDLE;
      finish    = 1'b0;
      abort_hit = 1'b1;
    end
  end

  // Operands and timing captured once in SETUP; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_SETUP) begin
      tpgm_q     <= rg_tpgm;
      trd_q      <= rg_trd;
      tlow_pgm_q <= rg_tlow_pgm;
      tlow_rd_q  <= rg_tlow_rd;
`ifdef EFUSE_PROG_VERIFY_EN
      wdata      <= write_data;
      wsel_q     <= write_sel;
`endif
    end
    if (state == S_SETUP)                  wsh <= write_data;
    else if (state == S_RECOV && recov_last) wsh <= wsh >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_wr      <= 1'b0;
      vfy        <= 1'b0;
      addr       <= '0;
      idx        <= '0;
      cnt        <= '0;
      read_data  <= '0;
      read_done  <= 1'b0;
      write_done <= 1'b0;
      aborted    <= 1'b0;
`ifdef EFUSE_PROG_VERIFY_EN
      verr       <= 1'b0;
`endif
    end else begin
      if (accept_rd || accept_wr) begin
        op_wr      <= accept_wr;
        vfy        <= 1'b0;
        read_done  <= 1'b0;
        write_done <= 1'b0;
        aborted    <= 1'b0;
`ifdef EFUSE_PROG_VERIFY_EN
        verr       <= 1'b0;
`endif
        if (accept_rd) read_data <= '0;
      end
      unique case (state)
        S_SETUP: begin
          cnt  <= '0;
          idx  <= '0;
          addr <= op_wr ? AW'(NW * int'(write_sel)) : AW'(RWORDS * int'(read_sel));
        end
        S_PULSE: begin
          if (pulse_last) begin
            cnt <= '0;
            if (!wr_phase) read_data <= {read_data[NR-DW-1:0], efuse.efuse_d};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RECOV: begin
          if (recov_last) begin
            cnt  <= '0;
            idx  <= idx + 1'b1;
            addr <= addr + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_VERIFY: begin
          cnt <= '0;
          idx <= '0;
`ifdef EFUSE_PROG_VERIFY_EN
          addr      <= AW'(VWORDS * int'(wsel_q));
          read_data <= '0;
`endif
        end
        default: ;
      endcase
      if (state_nx == S_VERIFY) vfy <= 1'b1;
      if (finish) begin
        if (op_wr) write_done <= 1'b1;
        else       read_done  <= 1'b1;
`ifdef EFUSE_PROG_VERIFY_EN
        if (op_wr) verr <= vfy & readback_miss(wdata, read_data);
`endif
      end
      if (abort_hit) aborted <= 1'b1;
    end
  end

  assign busy              = (state != S_IDLE);
  assign efuse.efuse_aen   = (state == S_PULSE);
  assign efuse.efuse_pgmen = busy & wr_phase;
  assign efuse.efuse_rden  = busy & ~wr_phase;
  assign efuse.efuse_addr  = addr;

`ifdef EFUSE_PROG_VERIFY_EN
  assign verify_err = verr;
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_prog_seq.sv
// Randomized bench for efuse_prog_seq against a fuse-array model and a
// per-operation pulse/timing reference computed from the sequencing rules.
module tb_efuse_prog_seq;
  localparam int NBITS = 256;
  localparam int DW    = 8;
  localparam int NW    = 64;
  localparam int NR    = 64;
  localparam int TW    = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, read_start, write_start, abort;
  logic [1:0]     read_sel, write_sel;
  logic [TW-1:0]  rg_trd, rg_tpgm;
  logic [3:0]     rg_tlow_rd, rg_tlow_pgm;
  logic [NW-1:0]  write_data;
  logic [NR-1:0]  read_data;
  logic           busy, read_done, write_done, aborted, verify_err;

  efuse_prog_seq_if #(.NBITS(NBITS), .DW(DW)) fuse_if ();

  efuse_prog_seq #(.NBITS(NBITS), .DW(DW), .NW(NW), .NR(NR), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .read_start(read_start), .write_start(write_start),
    .abort(abort), .read_sel(read_sel), .write_sel(write_sel), .rg_trd(rg_trd),
    .rg_tpgm(rg_tpgm), .rg_tlow_rd(rg_tlow_rd), .rg_tlow_pgm(rg_tlow_pgm),
    .write_data(write_data), .read_data(read_data), .efuse(fuse_if),
    .busy(busy), .read_done(read_done), .write_done(write_done),
    .aborted(aborted), .verify_err(verify_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] len;
    logic        pgm;
  } pulse_t;

  // Physical fuse array (owned by the monitor) and the bench's expected copy.
  logic   fuse [NBITS];
  bit     mdl  [NBITS];
  int     clr_req = 0, clr_ack = -1;
  int     stuck = -1;
  bit     d_addr_mode = 1'b0;
  pulse_t seen[$];
  pulse_t mon_p;
  int     cur_len = 0;

  always_comb begin
    fuse_if.efuse_d = '0;
    for (int j = 0; j < DW; j++)
      fuse_if.efuse_d[j] = d_addr_mode ? fuse_if.efuse_addr[j]
                                       : fuse[(int'(fuse_if.efuse_addr) * DW + j) % NBITS];
  end

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      for (int i = 0; i < NBITS; i++) fuse[i] = 1'b0;
      clr_ack = clr_req;
    end
    if (fuse_if.efuse_aen) begin
      if (cur_len == 0) begin
        mon_p.addr = 16'(fuse_if.efuse_addr);
        mon_p.pgm  = fuse_if.efuse_pgmen;
      end
      cur_len++;
      if (fuse_if.efuse_pgmen && int'(fuse_if.efuse_addr) != stuck)
        fuse[fuse_if.efuse_addr] = 1'b1;
    end else if (cur_len > 0) begin
      mon_p.len = 16'(cur_len);
      seen.push_back(mon_p);
      cur_len = 0;
    end
  end

  task automatic clear_fuses();
    clr_req++;
    for (int i = 0; i < NBITS; i++) mdl[i] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Expected read word stream: first word shifted furthest up.
  function automatic logic [63:0] exp_words(input int first);
    logic [63:0] r;
    logic [7:0]  w;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < DW; j++)
        w[j] = d_addr_mode ? ((first + k) >> j) & 1 : mdl[(first + k) * DW + j];
      r = (r << 8) | 64'(w);
    end
    return r;
  endfunction

  function automatic pulse_t mk(input int a, input int l, input bit p);
    pulse_t e;
    e.addr = 16'(a);
    e.len  = 16'(l);
    e.pgm  = p;
    return e;
  endfunction

  task automatic run_op(input bit is_wr, input bit both, input bit poke, input int sel,
                        input logic [63:0] wd, input int tp, input int tl, input string tag);
    pulse_t      exp_q[$];
    int          exp_busy, base, cyc, vt, vl, np;
    logic [63:0] exp_rd;
    bit          exp_verr, chk_rd;
    vt = $urandom_range(0, 5);
    vl = $urandom_range(0, 5);
    if (is_wr) begin
      rg_tpgm = TW'(tp); rg_tlow_pgm = 4'(tl); rg_trd = TW'(vt); rg_tlow_rd = 4'(vl);
      write_sel = 2'(sel); read_sel = 2'($urandom);
    end else begin
      rg_trd = TW'(tp); rg_tlow_rd = 4'(tl); rg_tpgm = TW'($urandom_range(0, 20));
      rg_tlow_pgm = 4'($urandom); read_sel = 2'(sel); write_sel = 2'($urandom);
    end
    write_data = wd;
    base = seen.size();
    @(negedge clk);
    write_start = is_wr | both;
    read_start  = !is_wr | both;
    @(negedge clk);
    write_start = 1'b0;
    read_start  = 1'b0;
    check_val({tag, "_busy_setup"}, busy, 1);
    cyc = 1;
    while (busy && cyc < 20000) begin
      @(negedge clk);
      if (cyc == 1) begin
        rg_trd = TW'($urandom); rg_tpgm = TW'($urandom);
        rg_tlow_rd = 4'($urandom); rg_tlow_pgm = 4'($urandom);
        write_data = {$urandom, $urandom};
        read_sel = 2'($urandom); write_sel = 2'($urandom);
      end
      if (poke) read_start = (cyc == 3);
      if (busy) cyc++;
    end
    read_start = 1'b0;

    exp_rd = '0; chk_rd = 1'b0; exp_verr = 1'b0;
    if (is_wr) begin
      exp_busy = 1;
      if (wd != 0) begin
        for (int i = 0; i < NW; i++) begin
          if (wd[i]) begin
            exp_q.push_back(mk(NW * sel + i, tp + 1, 1'b1));
            exp_busy += tp + tl + 2;
            if (NW * sel + i != stuck) mdl[NW * sel + i] = 1'b1;
          end else begin
            exp_busy += 1;
          end
        end
`ifdef EFUSE_PROG_VERIFY_EN
        exp_busy += 1 + (NW / DW) * (vt + vl + 2);
        for (int k = 0; k < NW / DW; k++) exp_q.push_back(mk((NW / DW) * sel + k, vt + 1, 1'b0));
        exp_rd = exp_words((NW / DW) * sel);
        chk_rd = 1'b1;
        for (int i = 0; i < NW; i++) if (wd[i] && !mdl[NW * sel + i]) exp_verr = 1'b1;
`endif
      end
    end else begin
      exp_busy = 1 + (NR / DW) * (tp + tl + 2);
      for (int k = 0; k < NR / DW; k++) exp_q.push_back(mk((NR / DW) * sel + k, tp + 1, 1'b0));
      exp_rd = exp_words((NR / DW) * sel);
      chk_rd = 1'b1;
    end

    check_val({tag, "_busy_cycles"}, cyc, exp_busy);
    np = seen.size() - base;
    check_val({tag, "_npulse"}, np, exp_q.size());
    for (int j = 0; j < np && j < exp_q.size(); j++)
      check_val($sformatf("%s_pulse%0d", tag, j), 64'(seen[base + j]), 64'(exp_q[j]));
    check_val({tag, "_write_done"}, write_done, is_wr | both);
    check_val({tag, "_read_done"}, read_done, !(is_wr | both));
    check_val({tag, "_aborted"}, aborted, 0);
    check_val({tag, "_verify_err"}, verify_err, exp_verr);
    if (chk_rd) check_val({tag, "_read_data"}, read_data, exp_rd);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g, base;
    logic [63:0] wd;
    rst_n = 1'b0; read_start = 1'b0; write_start = 1'b0; abort = 1'b0;
    read_sel = '0; write_sel = '0; rg_trd = '0; rg_tpgm = '0;
    rg_tlow_rd = '0; rg_tlow_pgm = '0; write_data = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check_val("rst_flags", {busy, read_done, write_done, aborted, verify_err,
               fuse_if.efuse_aen, fuse_if.efuse_pgmen, fuse_if.efuse_rden}, 0);
    check_val("rst_addr", fuse_if.efuse_addr, 0);
    check_val("rst_read_data", read_data, 0);
    rst_n = 1'b1;
    clear_fuses();

    run_op(1, 0, 0, 0, 64'h5, 9, 12, "w5");

    d_addr_mode = 1'b1;
    run_op(0, 0, 0, 1, 64'h0, 3, $urandom_range(0, 4), "rd_sel1");
    check_val("rd_sel1_value", read_data, 64'h08090A0B0C0D0E0F);
    d_addr_mode = 1'b0;

    run_op(1, 0, 0, 2, 64'h0, 5, 5, "wzero");

    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    check_val("idle_abort_busy", busy, 0);
    check_val("idle_abort_aborted", aborted, 0);
    check_val("idle_abort_done", write_done, 1);

    // Abort in the middle of the third programming pulse.
    rg_tpgm = TW'(9); rg_tlow_pgm = 4'(3); write_sel = 2'(1); write_data = 64'h7;
    base = seen.size();
    @(negedge clk); write_start = 1'b1;
    @(negedge clk); write_start = 1'b0;
    g = 0;
    while (!(fuse_if.efuse_aen && seen.size() - base == 2) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_val("abort_reach_pulse3", g < 2000, 1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_val("abort_aen", fuse_if.efuse_aen, 0);
    check_val("abort_pgmen", fuse_if.efuse_pgmen, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_flag", aborted, 1);
    check_val("abort_write_done", write_done, 0);
    repeat (2) @(negedge clk);
    check_val("abort_flag_held", aborted, 1);
    clear_fuses();

    run_op(1, 1, 1, 3, 64'h9, 4, 2, "both");
    repeat (3) @(negedge clk);
    check_val("both_idle", busy, 0);
    check_val("both_no_read", read_done, 0);

    clear_fuses();
    stuck = 1;
    run_op(1, 0, 0, 0, 64'h3, 2, 1, "stuck");
    stuck = -1;

    clear_fuses();
    for (int t = 0; t < 10; t++) begin
      wd = {$urandom, $urandom} & {$urandom, $urandom};
      run_op(1'($urandom), 0, 0, $urandom_range(0, 3), wd, $urandom_range(0, 12),
             $urandom_range(0, 15), $sformatf("rnd%0d", t));
    end

    // Reset asserted while a read pulse is in progress.
    rg_trd = TW'(20); rg_tlow_rd = 4'(2); read_sel = 2'(2);
    @(negedge clk); read_start = 1'b1;
    @(negedge clk); read_start = 1'b0;
    g = 0;
    while (!fuse_if.efuse_aen && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("rstp_reach_pulse", g < 100, 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_val("rstp_aen", fuse_if.efuse_aen, 0);
    check_val("rstp_busy", busy, 0);
    check_val("rstp_rden", fuse_if.efuse_rden, 0);
    check_val("rstp_addr", fuse_if.efuse_addr, 0);
    check_val("rstp_read_data", read_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
